// File: rtl/pll_rst_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// All signals are plain levels except i_soft_rst, which is a single-cycle
// pulse sampled on i_clk. There is no valid/ready pairing: outputs are
// registered every cycle, and a consumer may sample them on any cycle.
// The "slave" modport is the sequencer; the "master" modport is the
// environment (PLL wrapper, software, and the rest of the SoC).
interface pll_rst_sequencer_if;
   logic       i_locked;     // PLL lock indication, asynchronous to i_clk
   logic       i_soft_rst;   // synchronous single-cycle re-sequence request
   logic       o_pll_rst;    // reset to the PLL, active-high
   logic       o_rst;        // system reset, active-high
   logic       o_ready;      // high only in RUN
   logic       o_fail;       // high only in FAIL
   logic       o_lock_lost;  // sticky: lock dropped while in RUN
   logic [7:0] o_retry_cnt;  // retries consumed in the current sequence
   logic [2:0] o_dbg_state;  // current FSM state, for debug and checkers

   modport slave (
      input  i_locked, i_soft_rst,
      output o_pll_rst, o_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt,
             o_dbg_state
   );

   modport master (
      output i_locked, i_soft_rst,
      input  o_pll_rst, o_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt,
             o_dbg_state
   );
endinterface

// File: rtl/pll_rst_sequencer.sv
// PLL bring-up and system reset sequencer.
// Holds the PLL in reset, waits for lock with a timeout and bounded retries,
// requires lock to be stable before releasing the system reset, and
// re-sequences on lock loss or a software request.
module pll_rst_sequencer #(
   parameter int PLL_RST_CYCLES      = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 1024,
   parameter int LOCK_STABLE_CYCLES  = 16,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   pll_rst_sequencer_if.slave   bus
);

   // One shared counter serves all three timed states; it is cleared on
   // every state exit, so it is sized for the largest of the three limits.
   localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                              CNT_MAX_A : LOCK_STABLE_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_cnt_q, retry_cnt_d;
   logic             lock_lost_q, lock_lost_d;
   logic             pll_rst_q, pll_rst_d;
   logic             rst_q, rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic [1:0]       sync_q, sync_d;
   logic             locked_s;

   // Two-flop synchronizer input shift for the asynchronous lock signal.
   always_comb begin
      sync_d = {sync_q[0], bus.i_locked};
   end

   assign locked_s = sync_q[1];

   // Synchronizer registers, cleared to "not locked" on reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Next-state, counter, retry and sticky-flag logic; outputs are decoded
   // from the next state so they switch on the same edge as the state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_cnt_d = retry_cnt_q;
      lock_lost_d = lock_lost_q;

      if (bus.i_soft_rst) begin
         // Software request wins over everything and restarts the hold.
         state_d     = ST_PLL_RST;
         cnt_d       = '0;
         retry_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == PLL_RST_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  cnt_d = '0;
                  if (retry_cnt_q == RETRY_LIMIT) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d     = ST_PLL_RST;
                     retry_cnt_d = retry_cnt_q + 8'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               // A glitch in lock is not a retry: go back with a fresh timeout.
               if (!locked_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_d     = ST_PLL_RST;
                  cnt_d       = '0;
                  retry_cnt_d = '0;
                  lock_lost_d = 1'b1;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_PLL_RST;
               cnt_d   = '0;
            end
         endcase
      end

      pll_rst_d = (state_d == ST_PLL_RST);
      rst_d     = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
      fail_d    = (state_d == ST_FAIL);
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         retry_cnt_q <= '0;
         lock_lost_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         rst_q       <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_cnt_q <= retry_cnt_d;
         lock_lost_q <= lock_lost_d;
         pll_rst_q   <= pll_rst_d;
         rst_q       <= rst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign bus.o_pll_rst   = pll_rst_q;
   assign bus.o_rst       = rst_q;
   assign bus.o_ready     = ready_q;
   assign bus.o_fail      = fail_q;
   assign bus.o_lock_lost = lock_lost_q;
   assign bus.o_retry_cnt = retry_cnt_q;
   assign bus.o_dbg_state = state_q;

endmodule
